// File: rtl/qspi_slave.sv
// QSPI slave frame engine: single/dual/quad lanes, oversampled from sys_clk.
// chip_select, sclk and IO are resynchronised; SCLK must stay <= sys_clk/8.
module qspi_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic [1:0]            sel_mode,
    input  logic                  operation,
    input  logic                  chip_select,
    input  logic                  sclk,
    inout  wire  [3:0]            IO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_loaded,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_DUAL   = 2'b01;
    localparam logic [1:0] MODE_QUAD   = 2'b10;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    if (DATA_WIDTH % 4 != 0 || DATA_WIDTH < 8 || CPOL != 0 || CPHA != 0) begin : g_param_check
        $error("qspi_slave: unsupported DATA_WIDTH/CPOL/CPHA combination");
    end

    state_t state, state_nxt;

    logic cs_meta, cs_sync, cs_hist;
    logic sclk_meta, sclk_sync, sclk_hist;
    logic [3:0] io_meta, io_sync;
    logic cs_rise, cs_fall, sclk_rise, sclk_fall;

    logic                  cs_seen_high;
    logic [1:0]            mode_q;
    logic                  op_write;
    logic [CNT_W-1:0]      bit_cnt, last_cnt;
    logic [DATA_WIDTH-1:0] tx_shift, tx_next;
    logic [DATA_WIDTH-1:0] rx_shift, rx_next;
    logic [3:0]            io_oe, io_out;

    logic start_frame, abort_frame, rise_act, fall_act, last_rise;

    // NOTE: sequential state always uses <=, so each synchroniser stage
    // advances exactly one stage per clock instead of collapsing into one.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cs_meta   <= 1'b0;
            cs_sync   <= 1'b0;
            cs_hist   <= 1'b0;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_hist <= 1'b0;
            io_meta   <= 4'b0000;
            io_sync   <= 4'b0000;
        end else begin
            cs_meta   <= chip_select;
            cs_sync   <= cs_meta;
            cs_hist   <= cs_sync;
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_hist <= sclk_sync;
            io_meta   <= IO;
            io_sync   <= io_meta;
        end
    end

    assign cs_rise   =  cs_sync   & ~cs_hist;
    assign cs_fall   = ~cs_sync   &  cs_hist;
    assign sclk_rise =  sclk_sync & ~sclk_hist;
    assign sclk_fall = ~sclk_sync &  sclk_hist;

    // Index of the rising edge that completes a word in the latched mode.
    always_comb begin
        last_cnt = CNT_W'(DATA_WIDTH / 4 - 1);
        case (mode_q)
            MODE_SINGLE: last_cnt = CNT_W'(DATA_WIDTH - 1);
            MODE_DUAL:   last_cnt = CNT_W'(DATA_WIDTH / 2 - 1);
            default:     ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        abort_frame = 1'b0;
        rise_act    = 1'b0;
        fall_act    = 1'b0;
        last_rise   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall && cs_seen_high) begin
                    state_nxt   = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_nxt   = IDLE;
                    abort_frame = 1'b1;
                end else if (mode_q != 2'b11) begin
                    if (sclk_rise) begin
                        rise_act = 1'b1;
                        if (bit_cnt == last_cnt) begin
                            last_rise = 1'b1;
                            state_nxt = DONE;
                        end
                    end else if (sclk_fall) begin
                        fall_act = 1'b1;
                    end
                end
            end
            DONE: begin
                if (cs_sync) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // IO[0] always carries the most significant bit of each group.
    always_comb begin
        tx_next = tx_shift << 4;
        rx_next = {rx_shift[DATA_WIDTH-5:0], io_sync[0], io_sync[1], io_sync[2], io_sync[3]};
        case (mode_q)
            MODE_SINGLE: begin
                tx_next = tx_shift << 1;
                rx_next = {rx_shift[DATA_WIDTH-2:0], io_sync[0]};
            end
            MODE_DUAL: begin
                tx_next = tx_shift << 2;
                rx_next = {rx_shift[DATA_WIDTH-3:0], io_sync[0], io_sync[1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cs_seen_high <= 1'b0;
            mode_q       <= 2'b00;
            op_write     <= 1'b0;
            bit_cnt      <= '0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            tx_loaded    <= 1'b0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            tx_loaded <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (cs_sync) cs_seen_high <= 1'b1;
            if (start_frame) begin
                mode_q    <= sel_mode;
                op_write  <= operation;
                bit_cnt   <= '0;
                tx_shift  <= tx_data;
                rx_shift  <= '0;
                tx_loaded <= 1'b1;
            end
            if (rise_act) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (op_write) rx_shift <= rx_next;
            end
            if (fall_act && !op_write) tx_shift <= tx_next;
            if (last_rise && op_write) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
            end
            if (abort_frame) frame_err <= 1'b1;
        end
    end

    always_comb begin
        io_oe  = 4'b0000;
        io_out = {tx_shift[DATA_WIDTH-4], tx_shift[DATA_WIDTH-3],
                  tx_shift[DATA_WIDTH-2], tx_shift[DATA_WIDTH-1]};
        if (state == ACTIVE && !op_write) begin
            case (mode_q)
                MODE_SINGLE: begin
                    io_oe  = 4'b0010;
                    io_out = {2'b00, tx_shift[DATA_WIDTH-1], 1'b0};
                end
                MODE_DUAL: io_oe = 4'b0011;
                MODE_QUAD: io_oe = 4'b1111;
                default:   io_oe = 4'b0000;
            endcase
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign IO[i] = io_oe[i] ? io_out[i] : 1'bz;
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/qspi_slave.md
QSPI_SLAVE -- requirements
Module: qspi_slave

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, word length in bits; shall be a multiple of 4 and >= 8.
REQ-002 Parameter: CPOL, default 0, SCLK idle level; only 0 is supported.
REQ-003 Parameter: CPHA, default 0, SCLK sampling phase; only 0 is supported.
REQ-004 Port: sys_clk  in  1  the single clock; all flops clock on its rising edge.
REQ-005 Port: rst  in  1  reset; synchronous, active-high.
REQ-006 Port: sel_mode  in  2  00 single, 01 dual, 10 quad, 11 reserved; latched at frame start.
REQ-007 Port: operation  in  1  0 = master reads (this block drives IO), 1 = master writes (this block samples IO); latched at frame start.
REQ-008 Port: chip_select  in  1  active-low frame enable from the master; asynchronous to sys_clk.
REQ-009 Port: sclk  in  1  serial clock from the master; asynchronous to sys_clk; frequency <= sys_clk/8.
REQ-010 Port: IO  inout  4  tri-state data lanes; undriven lanes shall be 'z'.
REQ-011 Port: tx_data  in  DATA_WIDTH  word returned to the master on reads; sampled at frame start.
REQ-012 Port: tx_loaded  out  1  one-cycle pulse; tx_data was captured.
REQ-013 Port: rx_data  out  DATA_WIDTH  last complete word written by the master; held until the next complete word.
REQ-014 Port: rx_valid  out  1  one-cycle pulse; rx_data was updated.
REQ-015 Port: frame_err  out  1  one-cycle pulse; the frame ended incomplete or used reserved mode.
REQ-016 Port: busy  out  1  high while state != IDLE.

Function
REQ-017 chip_select, sclk and IO[3:0] inputs shall each pass through a 2-flop synchronizer; edges shall be detected by comparing the synchronized value with a third history flop.
REQ-018 FSM states: IDLE, ACTIVE, DONE.
REQ-019 IDLE: a synchronized chip_select falling edge shall be accepted only after chip_select was seen high since reset.
REQ-020 IDLE to ACTIVE on an accepted edge: latch sel_mode and operation, clear the bit counter, load the shifter from tx_data, and pulse tx_loaded.
REQ-021 Bits per SCLK edge: 1 (mode 00), 2 (01) or 4 (10); a word completes after DATA_WIDTH/bits rising edges.
REQ-022 Lane order: IO[0] carries the most significant bit of each group, then IO[1], IO[2], IO[3]; words are MSB first.
REQ-023 Lane use in single mode: the master-to-slave line is IO[0] and the slave-to-master line is IO[1].
REQ-024 Reads: the output enables of the used lanes (IO[1] in single mode; IO[1:0] in dual; IO[3:0] in quad) shall assert in the cycle after the frame-start edge, and the first group shall be driven before the first SCLK rise (CPHA=0).
REQ-025 Reads: on each detected SCLK falling edge, the shifter shall advance and the next group shall be driven.
REQ-026 Writes: on each detected SCLK rising edge, the synchronized IO group shall be shifted into the receive shifter; lanes are never driven.
REQ-027 ACTIVE to DONE on the final rising edge of the word.
REQ-028 Write frames: rx_data shall load and rx_valid shall pulse in the cycle after the final rising edge is detected, i.e. 3 sys_clk cycles after the final SCLK rise at the pin.
REQ-029 DONE: all output enables shall be deasserted and further SCLK edges ignored; the FSM shall move to IDLE when chip_select is high.
REQ-030 ACTIVE with chip_select rising before the word completes: go to IDLE, release IO, pulse frame_err, leave rx_data unchanged, no rx_valid.
REQ-031 Reserved mode 11: enter ACTIVE, never drive IO, ignore SCLK, and pulse frame_err on chip_select rising.
REQ-032 sel_mode, operation and tx_data changes during a frame shall have no effect until the next frame.

Reset
REQ-033 On rst: FSM to IDLE; all output enables off (IO = z); rx_data = 0; rx_valid, tx_loaded, frame_err and busy = 0; shifters, counter and synchronizers = 0; the chip_select-seen-high flag cleared.
REQ-034 Reset asserted mid-frame: the remainder of the frame is ignored, and a new frame is accepted only after chip_select goes high and then low again.

Verification
REQ-035 Single-mode read, tx_data=8'hA5 -> IO[1] carries 1,0,1,0,0,1,0,1 over 8 SCLK rises; IO[0], IO[2], IO[3] stay z; one tx_loaded pulse.
REQ-036 Quad-mode read, tx_data=8'h3C -> IO[3:0] = 4'b1100 at the first rise and 4'b0011 at the second rise; busy drops after chip_select rises.
REQ-037 Dual-mode write of 8'h5A (IO[0]/IO[1] pairs 01,01,10,10) -> rx_data=8'h5A with one rx_valid pulse 3 cycles after the 4th rise.
REQ-038 Quad-mode write of 8'hF0, then single-mode write of 8'hA5 -> rx_data=8'hF0, then 8'hA5; two rx_valid pulses; IO never driven.
REQ-039 Single-mode write with chip_select raised after 5 rises -> frame_err pulse, no rx_valid, rx_data unchanged; the next full frame succeeds.
REQ-040 rst pulsed after 3 rises of a quad read -> IO = z the next cycle; further SCLK edges are ignored until chip_select toggles high then low; sel_mode=11 frame -> no drive, frame_err pulse.
